// File: rtl/sm_table_loader.sv
// Run-time loadable next-state table plus the button state machine that steps through it.
// Loads one entry per accepted DATA beat, in ascending address order; RUN steps once per cycle, one-cycle latency.
module sm_table_loader #(
  parameter int STATE_W = 3,
  parameter int IN_W    = 3
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic                      BTNL,
  input  logic                      BTNC,
  input  logic                      BTNR,
  input  logic                      LOAD_START,
  input  logic                      DATA_VALID,
  input  logic [STATE_W-1:0]        DATA,
  output logic                      DATA_READY,
  output logic [STATE_W+IN_W-1:0]   LOAD_ADDR,
  output logic                      LOADING,
  output logic                      LOAD_DONE,
  output logic                      TABLE_VALID,
  output logic [7:0]                CHECKSUM,
  output logic [STATE_W-1:0]        STATE_OUT
);

  localparam int ADDR_W = STATE_W + IN_W;
  localparam int DEPTH  = 2**ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          csum_q;
  logic [STATE_W-1:0]  st_q;
  logic                ready_q;
  logic                done_q;
  logic                valid_q;

  logic [STATE_W-1:0]  mem [DEPTH];
  logic                wr_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [STATE_W-1:0]  rd_dat;

  // Writes only happen in LOAD and reads only matter in RUN, so no bypass is needed.
  assign wr_en   = ready_q && DATA_VALID && !LOAD_START;
  assign rd_addr = {st_q, BTNL, BTNC, BTNR};
  assign rd_dat  = mem[rd_addr];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[addr_q] <= DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      csum_q  <= '0;
      st_q    <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (LOAD_START) begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
            addr_q  <= '0;
            csum_q  <= '0;
            st_q    <= '0;
          end
        end
        S_LOAD: begin
          if (LOAD_START) begin
            addr_q <= '0;
            csum_q <= '0;
          end else if (DATA_VALID) begin
            addr_q <= addr_q + ADDR_W'(1);
            csum_q <= csum_q + 8'(DATA);
            // Final entry: hand over to RUN from state 0 with a one-cycle done pulse.
            if (&addr_q) begin
              state_q <= S_RUN;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              st_q    <= '0;
            end
          end
        end
        S_RUN: begin
          if (LOAD_START) begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
            addr_q  <= '0;
            csum_q  <= '0;
            st_q    <= '0;
          end else begin
            st_q <= rd_dat;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign DATA_READY  = ready_q;
  assign LOADING     = ready_q;
  assign LOAD_ADDR   = addr_q;
  assign LOAD_DONE   = done_q;
  assign TABLE_VALID = valid_q;
  assign CHECKSUM    = csum_q;
  assign STATE_OUT   = st_q;

endmodule

// File: tb/tb_sm_table_loader.sv
// Bench for sm_table_loader: transaction-level load/run model with randomized buttons and handshakes.
module tb_sm_table_loader;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       BTNL, BTNC, BTNR;
  logic       LOAD_START;
  logic       DATA_VALID;
  logic [2:0] DATA;
  logic       DATA_READY;
  logic [5:0] LOAD_ADDR;
  logic       LOADING;
  logic       LOAD_DONE;
  logic       TABLE_VALID;
  logic [7:0] CHECKSUM;
  logic [2:0] STATE_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] tbl_m [64];
  logic [2:0] src   [64];
  logic [2:0] s_m;
  logic [7:0] csum_m;
  logic       valid_m;

  sm_table_loader dut (
    .CLK(CLK), .RESETN(RESETN), .BTNL(BTNL), .BTNC(BTNC), .BTNR(BTNR),
    .LOAD_START(LOAD_START), .DATA_VALID(DATA_VALID), .DATA(DATA),
    .DATA_READY(DATA_READY), .LOAD_ADDR(LOAD_ADDR), .LOADING(LOADING),
    .LOAD_DONE(LOAD_DONE), .TABLE_VALID(TABLE_VALID), .CHECKSUM(CHECKSUM),
    .STATE_OUT(STATE_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_btn(input logic [2:0] b);
    BTNL = b[2];
    BTNC = b[1];
    BTNR = b[0];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(STATE_OUT),   32'd0);
    check({tag, "_addr"},  32'(LOAD_ADDR),   32'd0);
    check({tag, "_csum"},  32'(CHECKSUM),    32'd0);
    check({tag, "_rdy"},   32'(DATA_READY),  32'd0);
    check({tag, "_ldg"},   32'(LOADING),     32'd0);
    check({tag, "_done"},  32'(LOAD_DONE),   32'd0);
    check({tag, "_tv"},    32'(TABLE_VALID), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_btn(3'($urandom));
      DATA_VALID = 1'($urandom);
      DATA       = 3'($urandom);
      step();
      check("idle_state", 32'(STATE_OUT),   32'd0);
      check("idle_tv",    32'(TABLE_VALID), 32'd0);
      check("idle_rdy",   32'(DATA_READY),  32'd0);
      check("idle_addr",  32'(LOAD_ADDR),   32'd0);
    end
    DATA_VALID = 1'b0;
  endtask

  // Checks one RUN cycle: next state comes straight from the loaded table.
  task automatic run_step(input logic [2:0] b, input logic dv);
    logic [5:0] a;
    set_btn(b);
    DATA_VALID = dv;
    DATA       = 3'($urandom);
    a = {s_m, b};
    step();
    s_m = tbl_m[a];
    check("run_state", 32'(STATE_OUT),  32'(s_m));
    check("run_done",  32'(LOAD_DONE),  32'd0);
    check("run_rdy",   32'(DATA_READY), 32'd0);
    check("run_csum",  32'(CHECKSUM),   32'(csum_m));
    check("run_tv",    32'(TABLE_VALID), 32'd1);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) run_step(3'($urandom), 1'($urandom));
    DATA_VALID = 1'b0;
  endtask

  // mode 0: DATA_VALID held, 1: toggled every other cycle, 2: random.
  // abort_at / reset_at >= 0 restart the load or pulse reset when that address is reached.
  task automatic do_load(input int mode, input int abort_at, input int reset_at);
    int   idx;
    int   cyc;
    int   sum;
    bit   aborted;
    logic v;
    aborted = 1'b0;
    set_btn(3'($urandom));
    LOAD_START = 1'b1;
    DATA_VALID = 1'($urandom);
    DATA       = 3'($urandom);
    step();
    LOAD_START = 1'b0;
    check("ld_entry_rdy",   32'(DATA_READY),  32'd1);
    check("ld_entry_ldg",   32'(LOADING),     32'd1);
    check("ld_entry_addr",  32'(LOAD_ADDR),   32'd0);
    check("ld_entry_csum",  32'(CHECKSUM),    32'd0);
    check("ld_entry_state", 32'(STATE_OUT),   32'd0);
    check("ld_entry_tv",    32'(TABLE_VALID), 32'(valid_m));
    idx = 0;
    cyc = 0;
    while (idx < 64) begin
      if (cyc > 1000) begin
        check("ld_timeout", 32'(idx), 32'd64);
        break;
      end
      if (idx == reset_at) begin
        #1 RESETN = 1'b0;
        #1 check_reset_outputs("async_rst");
        valid_m    = 1'b0;
        s_m        = '0;
        csum_m     = '0;
        DATA_VALID = 1'b0;
        #2 RESETN = 1'b1;
        step();
        check_reset_outputs("post_rst");
        return;
      end
      if (idx == abort_at && !aborted) begin
        aborted    = 1'b1;
        LOAD_START = 1'b1;
        DATA_VALID = 1'b1;
        DATA       = ~src[idx];
        set_btn(3'($urandom));
        step();
        cyc++;
        LOAD_START = 1'b0;
        check("abort_addr", 32'(LOAD_ADDR),   32'd0);
        check("abort_csum", 32'(CHECKSUM),    32'd0);
        check("abort_tv",   32'(TABLE_VALID), 32'(valid_m));
        check("abort_ldg",  32'(LOADING),     32'd1);
        idx = 0;
        continue;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom);
      endcase
      DATA_VALID = v;
      DATA       = v ? src[idx] : 3'($urandom);
      set_btn(3'($urandom));
      check("ld_addr",  32'(LOAD_ADDR),   32'(idx));
      check("ld_rdy",   32'(DATA_READY),  32'd1);
      check("ld_done",  32'(LOAD_DONE),   32'd0);
      check("ld_state", 32'(STATE_OUT),   32'd0);
      check("ld_tv",    32'(TABLE_VALID), 32'(valid_m));
      step();
      cyc++;
      if (v) begin
        tbl_m[idx] = src[idx];
        idx++;
      end
    end
    if (mode == 0 && abort_at < 0) check("ld_cycles", 32'(cyc), 32'd64);
    sum = 0;
    for (int i = 0; i < 64; i++) sum += int'(src[i]);
    csum_m  = 8'(sum);
    valid_m = 1'b1;
    s_m     = '0;
    check("fin_done",  32'(LOAD_DONE),   32'd1);
    check("fin_tv",    32'(TABLE_VALID), 32'd1);
    check("fin_state", 32'(STATE_OUT),   32'd0);
    check("fin_rdy",   32'(DATA_READY),  32'd0);
    check("fin_ldg",   32'(LOADING),     32'd0);
    check("fin_addr",  32'(LOAD_ADDR),   32'd0);
    check("fin_csum",  32'(CHECKSUM),    32'(csum_m));
    // Source keeps DATA_VALID asserted past the last beat; nothing may be written.
    run_step(3'b000, 1'b1);
    DATA_VALID = 1'b0;
  endtask

  initial begin
    RESETN     = 1'b0;
    LOAD_START = 1'b0;
    DATA_VALID = 1'b0;
    DATA       = '0;
    set_btn(3'b000);
    valid_m = 1'b0;
    s_m     = '0;
    csum_m  = '0;
    #3 check_reset_outputs("reset");
    #9 RESETN = 1'b1;
    step();
    idle_cycles(10);

    for (int a = 0; a < 64; a++) src[a] = 3'((a >> 3) + 1);
    do_load(0, -1, -1);
    check("csum_e0", 32'(CHECKSUM), 32'hE0);
    run_random(20);

    do_load(1, -1, -1);
    check("csum_e0_toggle", 32'(CHECKSUM), 32'hE0);
    run_random(20);

    for (int a = 0; a < 64; a++) src[a] = ((a & 7) == 4) ? 3'((a >> 3) + 1) : 3'(a >> 3);
    do_load(2, -1, -1);
    for (int i = 0; i < 3; i++) begin
      run_step(3'b100, 1'b0);
      check("btnl_seq", 32'(STATE_OUT), 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      run_step(3'b000, 1'b0);
      check("btnl_hold", 32'(STATE_OUT), 32'd3);
    end

    for (int a = 0; a < 64; a++) src[a] = 3'($urandom);
    do_load(2, 20, -1);
    run_random(30);

    for (int a = 0; a < 64; a++) src[a] = 3'($urandom);
    do_load(0, -1, 40);
    idle_cycles(3);
    for (int a = 0; a < 64; a++) src[a] = 3'($urandom);
    do_load(2, -1, -1);
    run_random(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_table_loader.md
Name: sm_table_loader

Overview:
- Writer side of the ROM-driven button state machine: holds a 64-entry next-state table in RAM and loads it at run time over a valid/ready stream, instead of from a file at elaboration.
- Once the table is fully loaded, the block runs the state machine itself, stepping on {state, BTNL, BTNC, BTNR}.
- Sits between a host/UART byte source and the LED/state display logic.

Parameters:
- STATE_W, 3, width of the state register and of each table entry
- IN_W, 3, number of button inputs forming the low address bits
- DEPTH, 2**(STATE_W+IN_W) = 64, table entries; derived, not overridden

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESETN  input  1  asynchronous active-low reset
- BTNL  input  1  left button, already synchronised and debounced
- BTNC  input  1  centre button, already synchronised and debounced
- BTNR  input  1  right button, already synchronised and debounced
- LOAD_START  input  1  single-cycle request to (re)load the table
- DATA_VALID  input  1  DATA holds a table entry
- DATA  input  STATE_W  next-state value for the current load address
- DATA_READY  output  1  block accepts DATA this cycle
- LOAD_ADDR  output  STATE_W+IN_W  address the next accepted entry is written to
- LOADING  output  1  high while in LOAD
- LOAD_DONE  output  1  one-cycle pulse after the final entry is written
- TABLE_VALID  output  1  table fully loaded at least once since reset
- CHECKSUM  output  8  modulo-256 sum of the entries accepted in the current/last load
- STATE_OUT  output  STATE_W  current machine state

Behaviour:
- Reset (RESETN low, asynchronous): FSM=IDLE, STATE_OUT=0, LOAD_ADDR=0, CHECKSUM=0, DATA_READY=0, LOADING=0, LOAD_DONE=0, TABLE_VALID=0. Table RAM contents are not cleared.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - STATE_OUT held at 0; buttons ignored.
  - LOAD_START goes to LOAD.
- LOAD:
  - DATA_READY=1 and LOADING=1.
  - An entry is accepted when DATA_VALID && DATA_READY on a rising edge. On acceptance: table[LOAD_ADDR] <= DATA; LOAD_ADDR increments; CHECKSUM += zero-extended DATA (mod 256).
  - Entries load strictly in ascending address order 0..63; there is no random-access write.
  - Accepting the entry at address 63 moves to RUN on the next cycle. In that same edge: LOAD_ADDR wraps to 0; LOAD_DONE pulses high for exactly one cycle; TABLE_VALID is set; STATE_OUT is forced to 0.
  - LOAD_START during LOAD restarts the load: LOAD_ADDR=0, CHECKSUM=0, and the entry offered in that cycle is not written. LOAD_START has priority over DATA_VALID.
  - Buttons are ignored and STATE_OUT is held at 0 throughout LOAD.
- Entering LOAD from IDLE or RUN: LOAD_ADDR=0, CHECKSUM=0, STATE_OUT=0, TABLE_VALID unchanged. TABLE_VALID keeps its old value, so an aborted reload still reports the previous table as valid.
- RUN:
  - Every cycle: STATE_OUT <= table[{STATE_OUT, BTNL, BTNC, BTNR}]. Address MSBs are the state, LSB is BTNR.
  - Latency: one cycle from button change to the new STATE_OUT. The table read is combinational (distributed RAM).
  - LOAD_START in RUN goes to LOAD.
- Write and read never collide: the RAM is written only in LOAD and read only in RUN.
- DATA_READY deasserts in the cycle after the final acceptance. A source that keeps DATA_VALID high gets no extra writes.
- DATA_VALID outside LOAD is ignored and has no side effects.
- CHECKSUM holds its value through RUN until the next LOAD entry.

Test Plan:
- Reset, then 10 idle cycles with buttons toggling -> STATE_OUT=0, TABLE_VALID=0, DATA_READY=0 throughout.
- LOAD_START, then stream 64 entries with table[a] = a[5:3]+1 mod 8 (increment on any input), DATA_VALID held continuously -> 64 accepts in 64 cycles; LOAD_DONE pulses once after address 63; CHECKSUM=0xE0 (8×(1+...+8 mod 8 pattern) = 8×28 = 224); TABLE_VALID=1; STATE_OUT=0 on entering RUN.
- Same load with DATA_VALID toggled every other cycle -> only handshaked entries are written; LOAD_ADDR advances only on accept; final table and CHECKSUM are identical to the previous test.
- RUN with table[{s,3'b100}]=s+1, all other entries = s, BTNL held for 3 cycles -> STATE_OUT goes 1,2,3 on successive edges, then holds at 3 when BTNL is released.
- LOAD_START at LOAD_ADDR=20, then full reload -> LOAD_ADDR restarts at 0; CHECKSUM covers only the new 64 entries; the entry offered on the LOAD_START cycle is not written; TABLE_VALID stays 1 throughout.
- RESETN pulsed low mid-load at address 40 -> all outputs return to reset values immediately; TABLE_VALID=0; after a new full load, RUN uses the new table.
